// File: rtl/writeback_rob_if.sv
// Handshake bundle between issue/functional units and the in-order writeback buffer.
// The byp_* lookup signals exist only when ROB_BYPASS_EN is defined.
interface writeback_rob_if #(
  parameter int TAG_W = 3
);
  logic             alloc_valid;
  logic [4:0]       alloc_rd;
  logic             alloc_ready;
  logic [TAG_W-1:0] alloc_tag;
  logic             cpl_a_valid;
  logic [TAG_W-1:0] cpl_a_tag;
  logic [31:0]      cpl_a_data;
  logic             cpl_b_valid;
  logic [TAG_W-1:0] cpl_b_tag;
  logic [31:0]      cpl_b_data;
  logic             enc;
  logic [4:0]       addrc;
  logic [31:0]      datac;
  logic [TAG_W:0]   rob_count;
  logic             rob_empty;
`ifdef ROB_BYPASS_EN
  logic [4:0]       byp_addr;
  logic             byp_hit;
  logic             byp_ready;
  logic [31:0]      byp_data;

  modport master (
    output alloc_valid, alloc_rd, cpl_a_valid, cpl_a_tag, cpl_a_data,
           cpl_b_valid, cpl_b_tag, cpl_b_data, byp_addr,
    input  alloc_ready, alloc_tag, enc, addrc, datac, rob_count, rob_empty,
           byp_hit, byp_ready, byp_data
  );
  modport slave (
    input  alloc_valid, alloc_rd, cpl_a_valid, cpl_a_tag, cpl_a_data,
           cpl_b_valid, cpl_b_tag, cpl_b_data, byp_addr,
    output alloc_ready, alloc_tag, enc, addrc, datac, rob_count, rob_empty,
           byp_hit, byp_ready, byp_data
  );
`else
  modport master (
    output alloc_valid, alloc_rd, cpl_a_valid, cpl_a_tag, cpl_a_data,
           cpl_b_valid, cpl_b_tag, cpl_b_data,
    input  alloc_ready, alloc_tag, enc, addrc, datac, rob_count, rob_empty
  );
  modport slave (
    input  alloc_valid, alloc_rd, cpl_a_valid, cpl_a_tag, cpl_a_data,
           cpl_b_valid, cpl_b_tag, cpl_b_data,
    output alloc_ready, alloc_tag, enc, addrc, datac, rob_count, rob_empty
  );
`endif
endinterface

// File: rtl/writeback_rob.sv
// In-order retirement buffer: out-of-order completions drain in allocation order to the RF port.
// Define ROB_BYPASS_EN to add the combinational youngest-match forwarding lookup.
module writeback_rob #(
  parameter int DEPTH = 8,
  parameter int TAG_W = 3
) (
  input  logic            clock,
  input  logic            reset,
  writeback_rob_if.slave  bus
);
  localparam logic [TAG_W:0] FULL = (TAG_W+1)'(DEPTH);

  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] done_q;
  logic [4:0]       rd_q   [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [TAG_W-1:0] head_q;
  logic [TAG_W-1:0] tail_q;
  logic [TAG_W:0]   count_q;
  logic             enc_q;
  logic [4:0]       addrc_q;
  logic [31:0]      datac_q;

  logic alloc_fire;
  logic commit_fire;
  logic cpl_a_fire;
  logic cpl_b_fire;

  // Readiness ignores a same-cycle commit so a full buffer always refuses.
  assign alloc_fire  = bus.alloc_valid && (count_q != FULL);
  assign commit_fire = valid_q[head_q] && done_q[head_q];
  assign cpl_a_fire  = bus.cpl_a_valid && valid_q[bus.cpl_a_tag] && !done_q[bus.cpl_a_tag];
  assign cpl_b_fire  = bus.cpl_b_valid && valid_q[bus.cpl_b_tag] && !done_q[bus.cpl_b_tag]
                       && !(bus.cpl_a_valid && (bus.cpl_a_tag == bus.cpl_b_tag));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
      done_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      enc_q   <= 1'b0;
      addrc_q <= '0;
      datac_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        rd_q[i]   <= '0;
        data_q[i] <= '0;
      end
    end else begin
      enc_q <= 1'b0;
      if (alloc_fire) begin
        valid_q[tail_q] <= 1'b1;
        done_q[tail_q]  <= 1'b0;
        rd_q[tail_q]    <= bus.alloc_rd;
        tail_q          <= tail_q + 1'b1;
      end
      if (cpl_a_fire) begin
        data_q[bus.cpl_a_tag] <= bus.cpl_a_data;
        done_q[bus.cpl_a_tag] <= 1'b1;
      end
      if (cpl_b_fire) begin
        data_q[bus.cpl_b_tag] <= bus.cpl_b_data;
        done_q[bus.cpl_b_tag] <= 1'b1;
      end
      // Commit uses pre-edge state, so a completion never reaches the port on its own edge.
      if (commit_fire) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + 1'b1;
        enc_q           <= (rd_q[head_q] != 5'd0);
        addrc_q         <= rd_q[head_q];
        datac_q         <= data_q[head_q];
      end
      case ({alloc_fire, commit_fire})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign bus.enc         = enc_q;
  assign bus.addrc       = addrc_q;
  assign bus.datac       = datac_q;
  assign bus.rob_count   = count_q;
  assign bus.rob_empty   = (count_q == '0);
  assign bus.alloc_ready = (count_q != FULL);
  assign bus.alloc_tag   = tail_q;

`ifdef ROB_BYPASS_EN
  logic             byp_hit;
  logic             byp_ready;
  logic [31:0]      byp_data;
  logic [TAG_W-1:0] idx;

  // Valid entries are contiguous from head, so scanning by age lets the youngest match win.
  always_comb begin
    byp_hit   = 1'b0;
    byp_ready = 1'b0;
    byp_data  = '0;
    idx       = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + i[TAG_W-1:0];
      if ((bus.byp_addr != 5'd0) && valid_q[idx] && (rd_q[idx] == bus.byp_addr)) begin
        byp_hit   = 1'b1;
        byp_ready = done_q[idx];
        byp_data  = done_q[idx] ? data_q[idx] : 32'd0;
      end
    end
  end

  assign bus.byp_hit   = byp_hit;
  assign bus.byp_ready = byp_ready;
  assign bus.byp_data  = byp_data;
`endif
endmodule

// File: tb/tb_writeback_rob.sv
// Directed bench for writeback_rob: ordering, fill/wrap, port priority, rd=0, reset, optional bypass.
module tb_writeback_rob;
  localparam int TAG_W = 3;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   vectors = 0;
  int   errors  = 0;

  writeback_rob_if #(.TAG_W(TAG_W)) bus ();

  writeback_rob #(.DEPTH(8), .TAG_W(TAG_W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    bus.alloc_valid = 1'b0;
    bus.alloc_rd    = '0;
    bus.cpl_a_valid = 1'b0;
    bus.cpl_a_tag   = '0;
    bus.cpl_a_data  = '0;
    bus.cpl_b_valid = 1'b0;
    bus.cpl_b_tag   = '0;
    bus.cpl_b_data  = '0;
`ifdef ROB_BYPASS_EN
    bus.byp_addr    = '0;
`endif
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    step();
    step();
    vectors++;
    if ({bus.enc, bus.rob_empty, bus.alloc_ready, bus.alloc_tag, bus.rob_count} !== {1'b0, 1'b1, 1'b1, 3'd0, 4'd0}) begin
      errors++;
      $display("FAIL reset_status: got enc=%0b empty=%0b ready=%0b tag=%0d count=%0d want 0 1 1 0 0",
               bus.enc, bus.rob_empty, bus.alloc_ready, bus.alloc_tag, bus.rob_count);
    end
    vectors++;
    if ({bus.addrc, bus.datac} !== {5'd0, 32'd0}) begin
      errors++;
      $display("FAIL reset_port: got addrc=%0d datac=%h want 0 0", bus.addrc, bus.datac);
    end
  endtask

  task automatic test_out_of_order();
    do_reset();
    bus.alloc_valid = 1'b1;
    bus.alloc_rd    = 5'd3;
    step();
    bus.alloc_rd    = 5'd5;
    step();
    bus.alloc_valid = 1'b0;
    vectors++;
    if ({bus.alloc_tag, bus.rob_count} !== {3'd2, 4'd2}) begin
      errors++;
      $display("FAIL ooo_alloc: got tag=%0d count=%0d want 2 2", bus.alloc_tag, bus.rob_count);
    end
    bus.cpl_a_valid = 1'b1;
    bus.cpl_a_tag   = 3'd1;
    bus.cpl_a_data  = 32'hBBBB;
    step();
    bus.cpl_a_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if (bus.enc !== 1'b0) begin
        errors++;
        $display("FAIL ooo_wait%0d: got enc=%0b want 0", i, bus.enc);
      end
      step();
    end
    bus.cpl_a_valid = 1'b1;
    bus.cpl_a_tag   = 3'd0;
    bus.cpl_a_data  = 32'hAAAA;
    step();
    bus.cpl_a_valid = 1'b0;
    vectors++;
    if (bus.enc !== 1'b0) begin
      errors++;
      $display("FAIL ooo_no_forward: got enc=%0b want 0", bus.enc);
    end
    step();
    vectors++;
    if ({bus.enc, bus.addrc, bus.datac} !== {1'b1, 5'd3, 32'hAAAA}) begin
      errors++;
      $display("FAIL ooo_first: got enc=%0b addrc=%0d datac=%h want 1 3 0000aaaa", bus.enc, bus.addrc, bus.datac);
    end
    step();
    vectors++;
    if ({bus.enc, bus.addrc, bus.datac, bus.rob_count} !== {1'b1, 5'd5, 32'hBBBB, 4'd0}) begin
      errors++;
      $display("FAIL ooo_second: got enc=%0b addrc=%0d datac=%h count=%0d want 1 5 0000bbbb 0",
               bus.enc, bus.addrc, bus.datac, bus.rob_count);
    end
    step();
    vectors++;
    if ({bus.enc, bus.addrc, bus.datac, bus.rob_empty} !== {1'b0, 5'd5, 32'hBBBB, 1'b1}) begin
      errors++;
      $display("FAIL ooo_hold: got enc=%0b addrc=%0d datac=%h empty=%0b want 0 5 0000bbbb 1",
               bus.enc, bus.addrc, bus.datac, bus.rob_empty);
    end
  endtask

  task automatic test_fill_and_back_to_back();
    logic [2:0] pa [4];
    logic [2:0] pb [4];
    logic [2:0] t;
    logic [4:0] exp_rd;
    pa = '{3'd0, 3'd6, 3'd4, 3'd2};
    pb = '{3'd7, 3'd5, 3'd3, 3'd1};
    do_reset();
    bus.alloc_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.alloc_rd = 5'(8 + i);
      step();
    end
    vectors++;
    if ({bus.alloc_ready, bus.rob_count, bus.alloc_tag} !== {1'b0, 4'd8, 3'd0}) begin
      errors++;
      $display("FAIL fill_full: got ready=%0b count=%0d tag=%0d want 0 8 0", bus.alloc_ready, bus.rob_count, bus.alloc_tag);
    end
    bus.alloc_rd = 5'd20;
    step();
    vectors++;
    if ({bus.alloc_ready, bus.rob_count, bus.alloc_tag} !== {1'b0, 4'd8, 3'd0}) begin
      errors++;
      $display("FAIL fill_ninth: got ready=%0b count=%0d tag=%0d want 0 8 0", bus.alloc_ready, bus.rob_count, bus.alloc_tag);
    end
    bus.cpl_a_valid = 1'b1;
    bus.cpl_a_tag   = 3'd0;
    bus.cpl_a_data  = 32'h100;
    step();
    bus.cpl_a_valid = 1'b0;
    step();
    vectors++;
    if ({bus.enc, bus.addrc, bus.datac, bus.rob_count, bus.alloc_tag} !== {1'b1, 5'd8, 32'h100, 4'd7, 3'd0}) begin
      errors++;
      $display("FAIL fill_commit_refuse: got enc=%0b addrc=%0d datac=%h count=%0d tag=%0d want 1 8 00000100 7 0",
               bus.enc, bus.addrc, bus.datac, bus.rob_count, bus.alloc_tag);
    end
    step();
    bus.alloc_valid = 1'b0;
    vectors++;
    if ({bus.enc, bus.rob_count, bus.alloc_tag} !== {1'b0, 4'd8, 3'd1}) begin
      errors++;
      $display("FAIL fill_wrap_alloc: got enc=%0b count=%0d tag=%0d want 0 8 1", bus.enc, bus.rob_count, bus.alloc_tag);
    end
    for (int k = 0; k < 4; k++) begin
      bus.cpl_a_valid = 1'b1;
      bus.cpl_a_tag   = pa[k];
      bus.cpl_a_data  = 32'h200 + 32'(pa[k]);
      bus.cpl_b_valid = 1'b1;
      bus.cpl_b_tag   = pb[k];
      bus.cpl_b_data  = 32'h200 + 32'(pb[k]);
      step();
      vectors++;
      if (bus.enc !== 1'b0) begin
        errors++;
        $display("FAIL b2b_hold%0d: got enc=%0b want 0", k, bus.enc);
      end
    end
    bus.cpl_a_valid = 1'b0;
    bus.cpl_b_valid = 1'b0;
    for (int j = 0; j < 8; j++) begin
      t      = 3'(j + 1);
      exp_rd = (t == 3'd0) ? 5'd20 : 5'(8 + int'(t));
      step();
      vectors++;
      if ({bus.enc, bus.addrc, bus.datac} !== {1'b1, exp_rd, 32'h200 + 32'(t)}) begin
        errors++;
        $display("FAIL b2b_commit%0d: got enc=%0b addrc=%0d datac=%h want 1 %0d %h",
                 j, bus.enc, bus.addrc, bus.datac, exp_rd, 32'h200 + 32'(t));
      end
    end
    step();
    vectors++;
    if ({bus.enc, bus.rob_empty} !== {1'b0, 1'b1}) begin
      errors++;
      $display("FAIL b2b_drained: got enc=%0b empty=%0b want 0 1", bus.enc, bus.rob_empty);
    end
  endtask

  task automatic test_same_tag_and_rd_zero();
    do_reset();
    bus.alloc_valid = 1'b1;
    bus.alloc_rd    = 5'd1;
    step();
    bus.alloc_rd    = 5'd2;
    step();
    bus.alloc_rd    = 5'd4;
    step();
    bus.alloc_valid = 1'b0;
    bus.cpl_a_valid = 1'b1;
    bus.cpl_a_tag   = 3'd2;
    bus.cpl_a_data  = 32'h11;
    bus.cpl_b_valid = 1'b1;
    bus.cpl_b_tag   = 3'd2;
    bus.cpl_b_data  = 32'h22;
    step();
    bus.cpl_b_valid = 1'b0;
    bus.cpl_a_data  = 32'h33;
    step();
    bus.cpl_a_tag   = 3'd0;
    bus.cpl_a_data  = 32'h1;
    bus.cpl_b_valid = 1'b1;
    bus.cpl_b_tag   = 3'd1;
    bus.cpl_b_data  = 32'h2;
    step();
    bus.cpl_a_valid = 1'b0;
    bus.cpl_b_valid = 1'b0;
    vectors++;
    if (bus.enc !== 1'b0) begin
      errors++;
      $display("FAIL same_tag_wait: got enc=%0b want 0", bus.enc);
    end
    step();
    vectors++;
    if ({bus.enc, bus.addrc, bus.datac} !== {1'b1, 5'd1, 32'h1}) begin
      errors++;
      $display("FAIL same_tag_c0: got enc=%0b addrc=%0d datac=%h want 1 1 00000001", bus.enc, bus.addrc, bus.datac);
    end
    step();
    vectors++;
    if ({bus.enc, bus.addrc, bus.datac} !== {1'b1, 5'd2, 32'h2}) begin
      errors++;
      $display("FAIL same_tag_c1: got enc=%0b addrc=%0d datac=%h want 1 2 00000002", bus.enc, bus.addrc, bus.datac);
    end
    step();
    vectors++;
    if ({bus.enc, bus.addrc, bus.datac} !== {1'b1, 5'd4, 32'h11}) begin
      errors++;
      $display("FAIL same_tag_port_a: got enc=%0b addrc=%0d datac=%h want 1 4 00000011", bus.enc, bus.addrc, bus.datac);
    end
    bus.alloc_valid = 1'b1;
    bus.alloc_rd    = 5'd0;
    step();
    bus.alloc_valid = 1'b0;
    vectors++;
    if ({bus.rob_count, bus.alloc_tag} !== {4'd1, 3'd4}) begin
      errors++;
      $display("FAIL rd0_alloc: got count=%0d tag=%0d want 1 4", bus.rob_count, bus.alloc_tag);
    end
    bus.cpl_a_valid = 1'b1;
    bus.cpl_a_tag   = 3'd3;
    bus.cpl_a_data  = 32'h5A5A;
    step();
    bus.cpl_a_valid = 1'b0;
    step();
    vectors++;
    if ({bus.enc, bus.addrc, bus.datac, bus.rob_count, bus.rob_empty} !== {1'b0, 5'd0, 32'h5A5A, 4'd0, 1'b1}) begin
      errors++;
      $display("FAIL rd0_retire: got enc=%0b addrc=%0d datac=%h count=%0d empty=%0b want 0 0 00005a5a 0 1",
               bus.enc, bus.addrc, bus.datac, bus.rob_count, bus.rob_empty);
    end
  endtask

`ifdef ROB_BYPASS_EN
  task automatic test_bypass();
    do_reset();
    bus.alloc_valid = 1'b1;
    bus.alloc_rd    = 5'd7;
    step();
    step();
    bus.alloc_rd    = 5'd9;
    step();
    bus.alloc_valid = 1'b0;
    bus.cpl_a_valid = 1'b1;
    bus.cpl_a_tag   = 3'd1;
    bus.cpl_a_data  = 32'h77;
    step();
    bus.cpl_a_valid = 1'b0;
    bus.byp_addr    = 5'd7;
    #1;
    vectors++;
    if ({bus.byp_hit, bus.byp_ready, bus.byp_data} !== {1'b1, 1'b1, 32'h77}) begin
      errors++;
      $display("FAIL byp_young: got hit=%0b ready=%0b data=%h want 1 1 00000077", bus.byp_hit, bus.byp_ready, bus.byp_data);
    end
    bus.byp_addr = 5'd9;
    #1;
    vectors++;
    if ({bus.byp_hit, bus.byp_ready, bus.byp_data} !== {1'b1, 1'b0, 32'h0}) begin
      errors++;
      $display("FAIL byp_pending: got hit=%0b ready=%0b data=%h want 1 0 0", bus.byp_hit, bus.byp_ready, bus.byp_data);
    end
    bus.byp_addr = 5'd0;
    #1;
    vectors++;
    if ({bus.byp_hit, bus.byp_ready, bus.byp_data} !== {1'b0, 1'b0, 32'h0}) begin
      errors++;
      $display("FAIL byp_zero: got hit=%0b ready=%0b data=%h want 0 0 0", bus.byp_hit, bus.byp_ready, bus.byp_data);
    end
    bus.byp_addr = 5'd3;
    #1;
    vectors++;
    if ({bus.byp_hit, bus.byp_ready, bus.byp_data} !== {1'b0, 1'b0, 32'h0}) begin
      errors++;
      $display("FAIL byp_miss: got hit=%0b ready=%0b data=%h want 0 0 0", bus.byp_hit, bus.byp_ready, bus.byp_data);
    end
    bus.byp_addr = 5'd0;
  endtask
`endif

  task automatic test_reset_midstream();
    do_reset();
    bus.alloc_valid = 1'b1;
    bus.alloc_rd    = 5'd6;
    step();
    bus.alloc_rd    = 5'd9;
    step();
    bus.alloc_valid = 1'b0;
    bus.cpl_a_valid = 1'b1;
    bus.cpl_a_tag   = 3'd0;
    bus.cpl_a_data  = 32'h66;
    step();
    bus.cpl_a_valid = 1'b0;
    step();
    vectors++;
    if ({bus.enc, bus.addrc, bus.datac, bus.rob_count} !== {1'b1, 5'd6, 32'h66, 4'd1}) begin
      errors++;
      $display("FAIL mid_pre: got enc=%0b addrc=%0d datac=%h count=%0d want 1 6 00000066 1",
               bus.enc, bus.addrc, bus.datac, bus.rob_count);
    end
`ifdef ROB_BYPASS_EN
    bus.byp_addr = 5'd9;
`endif
    #2;
    reset = 1'b0;
    #1;
    vectors++;
    if ({bus.enc, bus.addrc, bus.datac} !== {1'b0, 5'd0, 32'd0}) begin
      errors++;
      $display("FAIL mid_port: got enc=%0b addrc=%0d datac=%h want 0 0 0", bus.enc, bus.addrc, bus.datac);
    end
    vectors++;
    if ({bus.rob_count, bus.rob_empty, bus.alloc_ready, bus.alloc_tag} !== {4'd0, 1'b1, 1'b1, 3'd0}) begin
      errors++;
      $display("FAIL mid_status: got count=%0d empty=%0b ready=%0b tag=%0d want 0 1 1 0",
               bus.rob_count, bus.rob_empty, bus.alloc_ready, bus.alloc_tag);
    end
`ifdef ROB_BYPASS_EN
    vectors++;
    if ({bus.byp_hit, bus.byp_ready, bus.byp_data} !== {1'b0, 1'b0, 32'h0}) begin
      errors++;
      $display("FAIL mid_byp: got hit=%0b ready=%0b data=%h want 0 0 0", bus.byp_hit, bus.byp_ready, bus.byp_data);
    end
    bus.byp_addr = 5'd0;
`endif
    @(posedge clock);
    #1;
    reset = 1'b1;
    bus.cpl_a_valid = 1'b1;
    bus.cpl_a_tag   = 3'd1;
    bus.cpl_a_data  = 32'h99;
    step();
    bus.cpl_a_valid = 1'b0;
    bus.alloc_valid = 1'b1;
    bus.alloc_rd    = 5'd5;
    step();
    bus.alloc_valid = 1'b0;
    step();
    vectors++;
    if ({bus.enc, bus.rob_count, bus.alloc_tag} !== {1'b0, 4'd1, 3'd1}) begin
      errors++;
      $display("FAIL mid_after: got enc=%0b count=%0d tag=%0d want 0 1 1", bus.enc, bus.rob_count, bus.alloc_tag);
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_out_of_order();
    test_fill_and_back_to_back();
    test_same_tag_and_rd_zero();
`ifdef ROB_BYPASS_EN
    test_bypass();
`endif
    test_reset_midstream();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
